sram_burst_ctrl: RTL

//  Upstream sequencer for the 128-bit 2R1W SRAM. Converts burst-read commands (start, length) into paired

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_burst_fifo.sv | 54 +++++
 rtl/sram_burst_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM burst sequencer: default widths,
// FSM states and the output beat bundle.
package sram_ctrl_pkg;

  localparam int ADDR_W_DFLT = 16;
  localparam int DATA_W_DFLT = 128;
  localparam int LEN_W_DFLT  = 16;
  localparam int FIFO_DEPTH_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT
  } state_e;

  typedef struct packed {
    logic [2*DATA_W_DFLT-1:0] data;
    logic [1:0]               mask;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/sram_burst_fifo.sv
// Beat FIFO between SRAM capture and the consumer; the count
// output feeds the read-issue credit check.
module sram_burst_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  beat_t         wdata_i,
  input  logic          pop_i,
  output beat_t         rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] cnt_o
);

  localparam int AW = $clog2(DEPTH);

  beat_t          mem_q [DEPTH];
  logic [AW-1:0]  wp_q;
  logic [AW-1:0]  rp_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rp_q];
  assign valid_o = (cnt_q != '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst-read sequencer and write-port owner for the 2R1W SRAM.
// Define SRAM_BURST_PERF_EN to add the stall/burst perf counters.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int LEN_W      = LEN_W_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic [1:0]          out_mask,
  output logic                out_last,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_waddr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [ADDR_W-1:0]   sram_raddr1,
  output logic [ADDR_W-1:0]   sram_raddr2,
  input  logic [DATA_W-1:0]   sram_rdata1,
`ifdef SRAM_BURST_PERF_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [15:0]         perf_burst_cnt,
`endif
  input  logic [DATA_W-1:0]   sram_rdata2
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              infl_q;
  logic [1:0]        pmask_q;
  logic              plast_q;
  logic              issue;
  logic              wr_fire;
  logic              credit_ok;
  logic              pop;
  logic              head_vld;
  logic [CW-1:0]     fifo_cnt;
  beat_t             head;
  beat_t             push_beat;

  // Count the in-flight read so a capture can never overflow the FIFO.
  assign credit_ok = (32'(fifo_cnt) + 32'(infl_q)) < 32'(FIFO_DEPTH);
  assign pop       = head_vld & out_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    issue     = 1'b0;
    wr_fire   = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready  = ~reset;
        cmd_ready = ~reset & ~wr_valid;
        wr_fire   = wr_valid & wr_ready;
        if (cmd_valid && cmd_ready && cmd_len != '0) begin
          ptr_d   = cmd_addr;
          rem_d   = cmd_len;
          state_d = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          ptr_d = ptr_q + ADDR_W'(2);
          rem_d = (rem_q > LEN_W'(2)) ? rem_q - LEN_W'(2) : '0;
          if (rem_q <= LEN_W'(2)) state_d = WAIT;
        end
      end
      WAIT: begin
        if (pop && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      pmask_q     <= 2'b00;
      plast_q     <= 1'b0;
      sram_we     <= 1'b0;
      sram_waddr  <= '0;
      sram_wdata  <= '0;
      sram_raddr1 <= '0;
      sram_raddr2 <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      infl_q  <= issue;
      sram_we <= wr_fire;
      if (wr_fire) begin
        sram_waddr <= wr_addr;
        sram_wdata <= wr_data;
      end
      if (issue) begin
        sram_raddr1 <= ptr_q;
        sram_raddr2 <= ptr_q + ADDR_W'(1);
        pmask_q     <= (rem_q == LEN_W'(1)) ? 2'b01 : 2'b11;
        plast_q     <= (rem_q <= LEN_W'(2));
      end
    end
  end

  // The FIFO write is the capture of the words returned for the last issue.
  assign push_beat.data = {sram_rdata2, sram_rdata1};
  assign push_beat.mask = pmask_q;
  assign push_beat.last = plast_q;

  sram_burst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (infl_q),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (head_vld),
    .cnt_o   (fifo_cnt)
  );

  assign out_valid = head_vld;
  assign out_data  = head_vld ? head.data : '0;
  assign out_mask  = head_vld ? head.mask : 2'b00;
  assign out_last  = head_vld & head.last;

`ifdef SRAM_BURST_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] bursts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (state_q == READ && !credit_ok && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (state_q == WAIT && pop && head.last)
        bursts_q <= bursts_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_burst_cnt = bursts_q;
`endif

endmodule
